// File: rtl/cnt_hex_scan_seg.sv
// Multi-digit hex up/down counter driving a time-multiplexed, active-low 7-segment display.
// Two free-running dividers produce the count tick and the per-digit scan tick.
module cnt_hex_scan_seg #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int CNT_FREQ  = 1,
  parameter int SCAN_FREQ = 1000,
  parameter int DIGITS    = 6,
  parameter int BLANK_LZ  = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clr,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg,
  output logic [4*DIGITS-1:0]   cnt_val,
  output logic                  carry
);

  localparam int DIV_CNT  = CLK_FREQ / CNT_FREQ;
  localparam int DIV_SCAN = CLK_FREQ / SCAN_FREQ;
  localparam int CDW      = $clog2(DIV_CNT);
  localparam int SDW      = $clog2(DIV_SCAN);
  localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW       = 4 * DIGITS;

  logic [CDW-1:0]          cnt_div;
  logic [SDW-1:0]          scan_div;
  logic [IW-1:0]           idx;
  logic                    cnt_tick, scan_tick;
  logic [DIGITS-1:0][3:0]  digs;
  logic [DIGITS-1:0]       sel_nxt;
  logic                    upper_zero, blank;

  assign cnt_tick  = (cnt_div  == CDW'(DIV_CNT - 1));
  assign scan_tick = (scan_div == SDW'(DIV_SCAN - 1));
  assign digs      = cnt_val;

  function automatic logic [7:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction

  // Clearing also realigns the count divider so the next tick is a full period away.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)               cnt_div <= '0;
    else if (clr || cnt_tick)  cnt_div <= '0;
    else                       cnt_div <= cnt_div + CDW'(1);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      scan_div <= '0;
      idx      <= '0;
    end else begin
      scan_div <= scan_tick ? '0 : scan_div + SDW'(1);
      if (scan_tick)
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_val <= '0;
      carry   <= 1'b0;
    end else if (clr) begin
      cnt_val <= '0;
      carry   <= 1'b0;
    end else if (cnt_tick && en) begin
      if (up_dn) begin
        cnt_val <= cnt_val + CW'(1);
        carry   <= &cnt_val;
      end else begin
        cnt_val <= cnt_val - CW'(1);
        carry   <= ~|cnt_val;
      end
    end else begin
      carry <= 1'b0;
    end
  end

  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++)
      if (k >= int'(idx) && digs[k] != 4'h0) upper_zero = 1'b0;
  end

  assign blank = (BLANK_LZ != 0) && (idx != '0) && upper_zero;

  always_comb begin
    sel_nxt      = '1;
    sel_nxt[idx] = 1'b0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel <= '1;
      seg <= 8'hFF;
    end else begin
      sel <= sel_nxt;
      seg <= blank ? 8'hFF : hex7(digs[idx]);
    end
  end

endmodule

// File: tb/tb_cnt_hex_scan_seg.sv
// Bench for cnt_hex_scan_seg: cycle model feeds an expected-output queue checked each negedge,
// plus directed checks for ticks, wrap/borrow, hold, clear priority, blanking and async reset.
module tb_cnt_hex_scan_seg;

  localparam int DIGITS = 4;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic en = 1'b1, up_dn = 1'b1, clr = 1'b0;
  logic [DIGITS-1:0]   sel, sel_b;
  logic [7:0]          seg, seg_b;
  logic [4*DIGITS-1:0] cnt_val, cnt_b;
  logic                carry, carry_b;

  int n_chk  = 0;
  int n_pass = 0;

  cnt_hex_scan_seg #(.CLK_FREQ(100), .CNT_FREQ(10), .SCAN_FREQ(50), .DIGITS(DIGITS), .BLANK_LZ(0)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .up_dn(up_dn), .clr(clr),
    .sel(sel), .seg(seg), .cnt_val(cnt_val), .carry(carry));

  cnt_hex_scan_seg #(.CLK_FREQ(100), .CNT_FREQ(10), .SCAN_FREQ(50), .DIGITS(DIGITS), .BLANK_LZ(1)) u_dut_lz (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .up_dn(up_dn), .clr(clr),
    .sel(sel_b), .seg(seg_b), .cnt_val(cnt_b), .carry(carry_b));

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  typedef struct {
    int          cdiv;
    int          sdiv;
    int          idx;
    logic [15:0] cnt;
    logic        carry;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic [7:0]  segb;
  } mstate_t;

  function automatic logic [7:0] ref_dec(input logic [3:0] d);
    case (d)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic mstate_t ref_reset();
    mstate_t r;
    r.cdiv = 0; r.sdiv = 0; r.idx = 0; r.cnt = 16'h0; r.carry = 1'b0;
    r.sel = 4'hF; r.seg = 8'hFF; r.segb = 8'hFF;
    return r;
  endfunction

  function automatic mstate_t ref_step(input mstate_t s, input logic e, input logic u, input logic c);
    mstate_t n;
    logic [3:0] nib;
    n   = s;
    nib = 4'(s.cnt >> (4 * s.idx));
    n.sel = 4'hF;
    n.sel[s.idx] = 1'b0;
    n.seg  = ref_dec(nib);
    n.segb = (s.idx > 0 && (s.cnt >> (4 * s.idx)) == 16'h0) ? 8'hFF : n.seg;
    n.carry = 1'b0;
    if (c) begin
      n.cnt  = 16'h0;
      n.cdiv = 0;
    end else begin
      if (s.cdiv == 9 && e) begin
        if (u) begin n.cnt = s.cnt + 16'd1; n.carry = (s.cnt == 16'hFFFF); end
        else   begin n.cnt = s.cnt - 16'd1; n.carry = (s.cnt == 16'h0000); end
      end
      n.cdiv = (s.cdiv == 9) ? 0 : s.cdiv + 1;
    end
    n.sdiv = (s.sdiv == 1) ? 0 : 1;
    n.idx  = (s.sdiv == 1) ? (s.idx + 1) % DIGITS : s.idx;
    return n;
  endfunction

  mstate_t m;
  mstate_t q[$];

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m <= ref_reset();
      q.delete();
    end else begin
      q.push_back(ref_step(m, en, up_dn, clr));
      m <= ref_step(m, en, up_dn, clr);
    end
  end

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      chk("rst_sel",   32'(sel),     'hF);
      chk("rst_seg",   32'(seg),     'hFF);
      chk("rst_cnt",   32'(cnt_val), 'h0);
      chk("rst_carry", 32'(carry),   'h0);
      chk("rst_sel_lz", 32'(sel_b),  'hF);
    end else if (q.size() != 0) begin
      chk("sb_cnt",    32'(cnt_val), 32'(q[0].cnt));
      chk("sb_carry",  32'(carry),   32'(q[0].carry));
      chk("sb_sel",    32'(sel),     32'(q[0].sel));
      chk("sb_seg",    32'(seg),     32'(q[0].seg));
      chk("sb_sel_lz", 32'(sel_b),   32'(q[0].sel));
      chk("sb_seg_lz", 32'(seg_b),   32'(q[0].segb));
      void'(q.pop_front());
    end
  end

  logic [3:0] prev_sel;
  logic       carry_seen;
  int         sel_moves;

  initial begin
    // 1: reset, then count up from zero
    repeat (3) @(negedge sys_clk);
    chk("dir_rst_sel", 32'(sel), 'hF);
    chk("dir_rst_seg", 32'(seg), 'hFF);
    #2 sys_rst = 1'b0;
    repeat (9) @(posedge sys_clk); #1;
    chk("cnt_pre_tick", 32'(cnt_val), 'h0);
    @(posedge sys_clk); #1;
    chk("cnt_first_tick", 32'(cnt_val), 'h1);
    chk("sel_edge10", 32'(sel), 'hE);
    chk("seg_edge10", 32'(seg), 'hC0);
    repeat (7) @(posedge sys_clk); #1;
    chk("sel_edge17", 32'(sel), 'hE);
    chk("seg_one", 32'(seg), 'hF9);

    // 2: borrow from 0000 to FFFF, then wrap back to 0000
    @(negedge sys_clk) clr = 1'b1;
    @(posedge sys_clk); #1;
    chk("clr_cnt", 32'(cnt_val), 'h0);
    @(negedge sys_clk) begin clr = 1'b0; up_dn = 1'b0; end
    repeat (10) @(posedge sys_clk); #1;
    chk("borrow_cnt", 32'(cnt_val), 'hFFFF);
    chk("borrow_carry", 32'(carry), 'h1);
    @(posedge sys_clk); #1;
    chk("borrow_carry_end", 32'(carry), 'h0);
    @(posedge sys_clk); #1;
    chk("seg_all_f", 32'(seg), 'h8E);
    @(negedge sys_clk) up_dn = 1'b1;
    repeat (8) @(posedge sys_clk); #1;
    chk("wrap_cnt", 32'(cnt_val), 'h0);
    chk("wrap_carry", 32'(carry), 'h1);
    @(posedge sys_clk); #1;
    chk("wrap_carry_end", 32'(carry), 'h0);
    chk("seg_zero", 32'(seg), 'hC0);

    // 4: clear landing on the same edge as a tick at 00A5
    @(negedge sys_clk) clr = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk) clr = 1'b0;
    repeat (1650) @(posedge sys_clk); #1;
    chk("cnt_a5", 32'(cnt_val), 'hA5);
    repeat (10) @(negedge sys_clk);
    clr = 1'b1;
    @(posedge sys_clk); #1;
    chk("clr_tick_cnt", 32'(cnt_val), 'h0);
    chk("clr_tick_carry", 32'(carry), 'h0);
    @(negedge sys_clk) clr = 1'b0;
    repeat (9) @(posedge sys_clk); #1;
    chk("post_clr_hold", 32'(cnt_val), 'h0);
    @(posedge sys_clk); #1;
    chk("post_clr_tick", 32'(cnt_val), 'h1);

    // 3: enable low for 50 cycles
    @(negedge sys_clk) en = 1'b0;
    prev_sel = sel; carry_seen = 1'b0; sel_moves = 0;
    repeat (50) begin
      @(posedge sys_clk); #1;
      if (carry) carry_seen = 1'b1;
      if (sel != prev_sel) sel_moves++;
      prev_sel = sel;
    end
    chk("hold_cnt", 32'(cnt_val), 'h1);
    chk("hold_carry", 32'(carry_seen), 'h0);
    chk("hold_scan", 32'(sel_moves), 25);
    @(negedge sys_clk) en = 1'b1;

    // 5: leading-zero blanking at 0030
    @(negedge sys_clk) clr = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk) clr = 1'b0;
    repeat (480) @(posedge sys_clk); #1;
    chk("cnt_30", 32'(cnt_b), 'h30);
    @(negedge sys_clk) en = 1'b0;
    repeat (8) begin
      @(posedge sys_clk); #1;
      case (sel_b)
        4'hE: chk("lz_d0", 32'(seg_b), 'hC0);
        4'hD: chk("lz_d1", 32'(seg_b), 'hB0);
        4'hB: begin
          chk("lz_d2", 32'(seg_b), 'hFF);
          chk("nolz_d2", 32'(seg), 'hC0);
        end
        4'h7: chk("lz_d3", 32'(seg_b), 'hFF);
        default: chk("lz_sel", 32'(sel_b), 'hE);
      endcase
    end

    // 6: asynchronous reset between edges
    @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    chk("async_sel", 32'(sel), 'hF);
    chk("async_seg", 32'(seg), 'hFF);
    chk("async_cnt", 32'(cnt_val), 'h0);
    chk("async_carry", 32'(carry), 'h0);
    chk("async_sel_lz", 32'(sel_b), 'hF);
    @(negedge sys_clk);
    #2 sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    chk("restart_sel0", 32'(sel), 'hE);
    @(posedge sys_clk); #1;
    chk("restart_sel1", 32'(sel), 'hE);
    @(posedge sys_clk); #1;
    chk("restart_sel2", 32'(sel), 'hD);

    repeat (2) @(negedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
